// File: rtl/add_share_arbiter_pkg.sv
// Shared constants and state encoding for the add-unit sharing arbiter.
// The FSM enum is tied to the numeric state codes so that debug views stay stable.
package add_arb_pkg;

    localparam int WIDTH_DEFAULT = 32;
    localparam int OPCNT_W       = 16;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_RESP  = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE  = S_IDLE,
        ST_ISSUE = S_ISSUE,
        ST_RESP  = S_RESP
    } arb_state_e;

endpackage

// File: rtl/add_share_arbiter_rr_arbiter.sv
// Round-robin grant generator: searches upward from the pointer with wrap and
// moves the pointer just past the winner whenever the grant is consumed.
module rr_arbiter
    import add_arb_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int IDW  = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [NREQ-1:0] req,
    input  logic            advance,
    output logic [NREQ-1:0] gnt_onehot,
    output logic [IDW-1:0]  gnt_idx
);

    logic [IDW-1:0] ptr_q;
    logic [IDW-1:0] ptr_d;
    logic [IDW-1:0] cand_idx [NREQ];
    logic           found;

    // cand_idx[k] is the requester examined k-th in this cycle's priority order.
    // One extra bit covers ptr + k before the wrap subtraction.
    generate
        for (genvar gi = 0; gi < NREQ; gi++) begin : g_cand
            logic [IDW:0] sum;
            assign sum = {1'b0, ptr_q} + (IDW+1)'(gi);
            assign cand_idx[gi] = (sum >= (IDW+1)'(NREQ)) ?
                                  IDW'(sum - (IDW+1)'(NREQ)) : sum[IDW-1:0];
        end
    endgenerate

    always_comb begin
        found      = 1'b0;
        gnt_idx    = '0;
        gnt_onehot = '0;
        for (int k = 0; k < NREQ; k++) begin
            if (!found && req[cand_idx[k]]) begin
                found   = 1'b1;
                gnt_idx = cand_idx[k];
            end
        end
        if (found) begin
            gnt_onehot[gnt_idx] = 1'b1;
        end
    end

    always_comb begin
        ptr_d = ptr_q;
        if (advance && found) begin
            ptr_d = (gnt_idx == IDW'(NREQ-1)) ? '0 : gnt_idx + IDW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/add_share_arbiter.sv
// Time-shares one external adder between NREQ requesters: grant, drive registered
// operands for one cycle, capture the sum, and return it over a valid/ready channel.
module add_share_arbiter
    import add_arb_pkg::*;
#(
    parameter int NREQ  = 4,
    parameter int WIDTH = WIDTH_DEFAULT,
    parameter int IDW   = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NREQ-1:0]       req_valid,
    input  logic [NREQ*WIDTH-1:0] req_a,
    input  logic [NREQ*WIDTH-1:0] req_b,
    output logic [NREQ-1:0]       req_ready,
    output logic [WIDTH-1:0]      add_a,
    output logic [WIDTH-1:0]      add_b,
    input  logic [WIDTH-1:0]      add_out,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [IDW-1:0]        rsp_id,
    output logic [WIDTH-1:0]      rsp_sum,
    output logic                  busy,
    output logic [OPCNT_W-1:0]    op_count
);

    arb_state_e           state_q,     state_d;
    logic [WIDTH-1:0]     add_a_q,     add_a_d;
    logic [WIDTH-1:0]     add_b_q,     add_b_d;
    logic [IDW-1:0]       id_q,        id_d;
    logic                 rsp_valid_q, rsp_valid_d;
    logic [IDW-1:0]       rsp_id_q,    rsp_id_d;
    logic [WIDTH-1:0]     rsp_sum_q,   rsp_sum_d;
    logic [OPCNT_W-1:0]   op_count_q,  op_count_d;

    logic [WIDTH-1:0]     op_a [NREQ];
    logic [WIDTH-1:0]     op_b [NREQ];
    logic [NREQ-1:0]      gnt_onehot;
    logic [IDW-1:0]       gnt_idx;
    logic                 accept;

    generate
        for (genvar gi = 0; gi < NREQ; gi++) begin : g_unpack
            assign op_a[gi] = req_a[gi*WIDTH +: WIDTH];
            assign op_b[gi] = req_b[gi*WIDTH +: WIDTH];
        end
    endgenerate

    // A grant is only offered in IDLE; any valid request there is accepted.
    assign accept    = rst_n && (state_q == ST_IDLE) && (|req_valid);
    assign req_ready = (rst_n && (state_q == ST_IDLE)) ? gnt_onehot : '0;

    rr_arbiter #(
        .NREQ (NREQ),
        .IDW  (IDW)
    ) u_rr_arbiter (
        .clk        (clk),
        .rst_n      (rst_n),
        .req        (req_valid),
        .advance    (accept),
        .gnt_onehot (gnt_onehot),
        .gnt_idx    (gnt_idx)
    );

    always_comb begin
        state_d     = state_q;
        add_a_d     = add_a_q;
        add_b_d     = add_b_q;
        id_d        = id_q;
        rsp_valid_d = rsp_valid_q;
        rsp_id_d    = rsp_id_q;
        rsp_sum_d   = rsp_sum_q;
        op_count_d  = op_count_q;
        unique case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    add_a_d = op_a[gnt_idx];
                    add_b_d = op_b[gnt_idx];
                    id_d    = gnt_idx;
                    state_d = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                rsp_sum_d   = add_out;
                rsp_id_d    = id_q;
                rsp_valid_d = 1'b1;
                state_d     = ST_RESP;
            end
            ST_RESP: begin
                // Operands stay on the adder until the consumer takes the result.
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    op_count_d  = op_count_q + OPCNT_W'(1);
                    state_d     = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            add_a_q     <= '0;
            add_b_q     <= '0;
            id_q        <= '0;
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= '0;
            rsp_sum_q   <= '0;
            op_count_q  <= '0;
        end else begin
            state_q     <= state_d;
            add_a_q     <= add_a_d;
            add_b_q     <= add_b_d;
            id_q        <= id_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_id_q    <= rsp_id_d;
            rsp_sum_q   <= rsp_sum_d;
            op_count_q  <= op_count_d;
        end
    end

    assign add_a     = add_a_q;
    assign add_b     = add_b_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_id    = rsp_id_q;
    assign rsp_sum   = rsp_sum_q;
    assign busy      = (state_q != ST_IDLE);
    assign op_count  = op_count_q;

endmodule

// File: tb/tb_add_share_arbiter.sv
// Directed bench for add_share_arbiter: a transaction-level model checked every
// cycle, plus hand-computed literal expectations for each scenario.
module tb_add_share_arbiter;

    localparam int NREQ = 4;
    localparam int W    = 32;
    localparam int IDW  = 2;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [NREQ-1:0] req_valid;
    logic [W-1:0]    opa [NREQ];
    logic [W-1:0]    opb [NREQ];
    logic [NREQ*W-1:0] req_a;
    logic [NREQ*W-1:0] req_b;
    logic [NREQ-1:0] req_ready;
    logic [W-1:0]    add_a;
    logic [W-1:0]    add_b;
    logic [W-1:0]    add_out;
    logic            rsp_valid;
    logic            rsp_ready;
    logic [IDW-1:0]  rsp_id;
    logic [W-1:0]    rsp_sum;
    logic            busy;
    logic [15:0]     op_count;

    assign req_a   = {opa[3], opa[2], opa[1], opa[0]};
    assign req_b   = {opb[3], opb[2], opb[1], opb[0]};
    assign add_out = add_a + add_b;   // the shared adder itself

    add_share_arbiter #(.NREQ(NREQ), .WIDTH(W), .IDW(IDW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_ready (req_ready),
        .add_a     (add_a),
        .add_b     (add_b),
        .add_out   (add_out),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_id    (rsp_id),
        .rsp_sum   (rsp_sum),
        .busy      (busy),
        .op_count  (op_count)
    );

    always #5 clk = ~clk;

    int  n_tests = 0;
    int  n_fail  = 0;
    bit  chk_en  = 1'b0;
    bit  rec_en  = 1'b0;

    // Model: phase 0 = waiting for a request, 1 = operands on the adder, 2 = result offered.
    int          m_phase = 0;
    int          m_ptr   = 0;
    logic [1:0]  m_id    = '0;
    logic [1:0]  m_rid   = '0;
    logic [W-1:0] m_a    = '0;
    logic [W-1:0] m_b    = '0;
    logic [W-1:0] m_rsum = '0;
    logic [15:0] m_cnt   = '0;

    int          rec_id  [$];
    logic [W-1:0] rec_sum [$];

    function automatic int first_valid(logic [NREQ-1:0] v, int p);
        for (int k = 0; k < NREQ; k++) begin
            int idx;
            idx = (p + k) % NREQ;
            if (v[idx]) return idx;
        end
        return -1;
    endfunction

    task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, required 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(posedge clk) begin
        int g;
        if (!rst_n) begin
            m_phase = 0; m_ptr = 0; m_id = '0; m_rid = '0;
            m_a = '0; m_b = '0; m_rsum = '0; m_cnt = '0;
        end else begin
            case (m_phase)
                0: begin
                    g = first_valid(req_valid, m_ptr);
                    if (g >= 0) begin
                        m_a = opa[g]; m_b = opb[g]; m_id = 2'(g);
                        m_ptr = (g + 1) % NREQ;
                        m_phase = 1;
                    end
                end
                1: begin
                    m_rsum = m_a + m_b;
                    m_rid = m_id;
                    m_phase = 2;
                end
                default: begin
                    if (rsp_ready) begin
                        m_cnt = m_cnt + 16'd1;
                        m_phase = 0;
                    end
                end
            endcase
        end
    end

    always @(negedge clk) begin
        int g;
        logic [NREQ-1:0] er;
        if (chk_en) begin
            g = first_valid(req_valid, m_ptr);
            er = (rst_n && m_phase == 0 && g >= 0) ? NREQ'(1 << g) : '0;
            chk("req_ready", req_ready, er);
            chk("rsp_valid", rsp_valid, m_phase == 2);
            chk("busy", busy, m_phase != 0);
            chk("add_a", add_a, m_a);
            chk("add_b", add_b, m_b);
            chk("rsp_id", rsp_id, m_rid);
            chk("rsp_sum", rsp_sum, m_rsum);
            chk("op_count", op_count, m_cnt);
            if (rec_en && rsp_valid && rsp_ready) begin
                rec_id.push_back(int'(rsp_id));
                rec_sum.push_back(rsp_sum);
                $display("[TB] response id=%0d sum=%0d", rsp_id, rsp_sum);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        @(negedge clk);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, required $finish");
        $fatal(1);
    end

    initial begin
        int          exp_ids  [5];
        logic [W-1:0] exp_sums [5];
        logic [IDW-1:0] snap_id;
        logic [W-1:0]   snap_sum;
        exp_ids  = '{0, 1, 2, 3, 0};
        exp_sums = '{32'd100, 32'd2, 32'd15, 32'd300, 32'd100};
        for (int i = 0; i < NREQ; i++) begin
            opa[i] = '0;
            opb[i] = '0;
        end
        rst_n = 1'b0; rsp_ready = 1'b1; req_valid = 4'b1111;

        // Reset held two cycles with every requester asking
        step; chk_en = 1'b1; step; settle;
        chk("reset_req_ready", req_ready, 4'b0000);
        chk("reset_rsp_valid", rsp_valid, 1'b0);
        chk("reset_add_a", add_a, 32'd0);
        chk("reset_add_b", add_b, 32'd0);
        chk("reset_op_count", op_count, 16'd0);
        chk("reset_busy", busy, 1'b0);
        $display("[TB] reset checked");

        // Reset while a result is waiting in RESP
        step; rst_n = 1'b1; req_valid = 4'b0100; opa[2] = 32'd5; opb[2] = 32'd6; rsp_ready = 1'b0;
        step; req_valid = 4'b0000;
        step; settle;
        chk("midop_rsp_valid_pre", rsp_valid, 1'b1);
        step; rst_n = 1'b0;
        step; settle;
        chk("midop_rsp_valid_drop", rsp_valid, 1'b0);
        chk("midop_op_count", op_count, 16'd0);
        step; rst_n = 1'b1; req_valid = 4'b1111; opa[0] = 32'd10; opb[0] = 32'd20; rsp_ready = 1'b1;
        settle;
        chk("midop_first_grant", req_ready, 4'b0001);
        step; req_valid = 4'b0000;
        step; settle;
        chk("midop_post_sum", rsp_sum, 32'd30);
        chk("midop_post_id", rsp_id, 2'd0);
        step;
        $display("[TB] mid-op reset checked");

        // Single request from requester 2
        req_valid = 4'b0100; opa[2] = 32'd4; opb[2] = 32'd9;
        settle;
        chk("single_grant", req_ready, 4'b0100);
        step; req_valid = 4'b0000;
        step; settle;
        chk("single_rsp_valid", rsp_valid, 1'b1);
        chk("single_rsp_id", rsp_id, 2'd2);
        chk("single_rsp_sum", rsp_sum, 32'd13);
        step; settle;
        chk("single_op_count", op_count, 16'd2);
        chk("single_rsp_done", rsp_valid, 1'b0);
        $display("[TB] single request checked");

        // Modulo wrap of the sum, requester 3 (leaves the pointer at 0)
        req_valid = 4'b1000; opa[3] = 32'hFFFF_FFFF; opb[3] = 32'h0000_0001;
        step; req_valid = 4'b0000;
        step; settle;
        chk("wrap_sum", rsp_sum, 32'd0);
        chk("wrap_id", rsp_id, 2'd3);
        step;
        $display("[TB] sum wrap checked");

        // All four requesters held valid
        opa[0] = 32'd22; opb[0] = 32'd78;
        opa[1] = 32'd1;  opb[1] = 32'd1;
        opa[2] = 32'd7;  opb[2] = 32'd8;
        opa[3] = 32'd100; opb[3] = 32'd200;
        req_valid = 4'b1111; rec_en = 1'b1;
        repeat (15) step;
        req_valid = 4'b0000; rec_en = 1'b0;
        chk("rr_count", rec_id.size(), 5);
        for (int i = 0; i < 5 && i < rec_id.size(); i++) begin
            chk("rr_id", rec_id[i], exp_ids[i]);
            chk("rr_sum", rec_sum[i], exp_sums[i]);
        end

        // Backpressure with other requests pending
        req_valid = 4'b1111; rsp_ready = 1'b0;
        step; step; settle;
        snap_id = rsp_id; snap_sum = rsp_sum;
        chk("bp_first_id", snap_id, 2'd1);
        chk("bp_first_sum", snap_sum, 32'd2);
        for (int c = 0; c < 5; c++) begin
            step; settle;
            chk("bp_hold_sum", rsp_sum, 32'd2);
            chk("bp_hold_id", rsp_id, 2'd1);
            chk("bp_hold_ready", req_ready, 4'b0000);
            chk("bp_hold_valid", rsp_valid, 1'b1);
        end
        step; rsp_ready = 1'b1;
        step; settle;
        chk("bp_next_grant", req_ready, 4'b0100);
        step; req_valid = 4'b0000;
        step; step;
        $display("[TB] backpressure checked");

        // op_count rollover
        #1;
        dut.op_count_q = 16'hFFFF;
        m_cnt = 16'hFFFF;
        settle;
        chk("cnt_preload", op_count, 16'hFFFF);
        step; req_valid = 4'b0001; opa[0] = 32'd3; opb[0] = 32'd4;
        step; req_valid = 4'b0000;
        step; step; settle;
        chk("cnt_wrap", op_count, 16'h0000);
        $display("[TB] op_count wrap checked");

        chk_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
